sg_mem_responder: RTL and testbench
===================================

Name: sg_mem_responder

Overview:
- Memory-side responder for the scatter/gather engine. It accepts word requests (gather = read, scatter = write) on a valid/ready request channel and services them from an internal word-addressed scratchpad.
- Returns one in-order response per request on a valid/ready response channel.
- Flags misaligned and out-of-window byte addresses as errors instead of accessing memory.

Parameters:
- DEPTH, 256, scratchpad size in 32-bit words (power of two, ≥4)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (must be 4-byte aligned)
- RSP_DEPTH, 4, response FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = scatter (write), 0 = gather (read)
- req_addr  input  32  byte address (base + index*4 as produced by the engine)
- req_wdata  input  32  write data, ignored when req_we=0
- rsp_valid  output  1  response at FIFO head
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_data  output  32  read data; 0 for writes and for errors
- rsp_err  output  1  request was misaligned or out of window
- rsp_we  output  1  echo of req_we for the response

Behaviour:
- Reset (rst=1 at an edge):
  - Stage register invalid, FIFO empty.
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_we=0.
  - req_ready=1 in the cycle after reset.
  - Scratchpad contents are not reset and retain their values.
- Accept: the request is accepted at an edge where req_valid && req_ready.
- Decode at accept:
  - off = req_addr − BASE_ADDR (32-bit modular subtraction).
  - err = (req_addr[1:0] != 0) || (off[31:2] >= DEPTH).
  - idx = off[2+log2(DEPTH)−1:2].
- Memory access happens at the accept edge. Results go into the stage register s1 (valid, we, err, data).
  - Write, no err: mem[idx] ← req_wdata; s1.data=0.
  - Read, no err: s1.data ← mem[idx], the value before any write at this edge. Only one request is accepted per edge.
  - err: memory is untouched and s1.data=0.
- Edge after accept: if s1 is valid, s1 is pushed into the FIFO and s1 is cleared. A new request may refill s1 at the same edge.
- Latency: request accepted at edge N → rsp_valid high in the cycle after edge N+1 if the FIFO was empty. There is no bypass.
- Ordering:
  - Responses are strictly in request order.
  - Read-after-write to the same word on consecutive accepts returns the new data, because the write completes at the earlier edge.
- Flow control:
  - req_ready = (fifo_count + s1.valid) < RSP_DEPTH, driven from registers only, with no combinational path from rsp_ready or req_valid.
  - This guarantees the FIFO never overflows.
- Response channel:
  - rsp_* show the FIFO head.
  - The head pops at an edge with rsp_valid && rsp_ready.
  - rsp_* outputs stay stable while rsp_valid && !rsp_ready.
- Full / empty:
  - Push and pop at the same edge with the FIFO full is legal; the count is unchanged.
  - A pop with the FIFO empty is ignored.
  - FIFO pointers wrap modulo RSP_DEPTH.
- Sustained throughput: one request per cycle when rsp_ready is held high.
- Reset mid-operation: in-flight s1 contents and queued responses are discarded without being emitted. A write already accepted before the reset edge remains in memory.
- Address boundaries:
  - req_addr = BASE_ADDR + 4*(DEPTH−1) is valid.
  - BASE_ADDR + 4*DEPTH is an error.
  - Addresses below BASE_ADDR wrap to a large off and are errors.

Optional Feature:
- Macro: SG_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [15:0], reset to 0.
  - err_cnt increments by 1 on every accepted request with err=1 and saturates at 16'hFFFF.
  - Adds input err_cnt_clr [1]. It clears the count to 0 at the edge where it is sampled high; clear wins over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Write 32'hDEAD_BEEF to BASE_ADDR+8, then read BASE_ADDR+8 back-to-back with rsp_ready=1 → two responses in order: {we=1, data=0, err=0}, then {we=0, data=DEADBEEF, err=0}. The first rsp_valid appears 2 cycles after the write accept.
- Read BASE_ADDR+4*(DEPTH−1) after writing 32'h1234_5678 there → data 12345678, err=0. Read BASE_ADDR+4*DEPTH → err=1, data=0, memory unchanged.
- Read BASE_ADDR+2 and BASE_ADDR−4 → both err=1, data=0. With SG_ERR_CNT_EN defined, err_cnt=2; pulsing err_cnt_clr returns it to 0.
- Hold rsp_ready=0 and issue 6 reads → exactly RSP_DEPTH=4 are accepted and req_ready drops to 0. Release rsp_ready → 4 responses in order, then the remaining 2 are accepted and returned.
- Stream 16 reads with rsp_ready=1 → one request accepted per cycle, rsp_valid continuously high after the initial 2-cycle latency, data matches the preloaded pattern.
- Fill the FIFO with 3 responses, assert rst for 1 cycle → rsp_valid=0 the next cycle and no stale responses are emitted. Data written before the reset reads back correctly afterwards.

Source files
------------

// File: rtl/sg_mem_if.sv
// Request/response channel bundle between the scatter/gather engine (master)
// and the memory-side responder (slave).
interface sg_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_we
  );
endinterface

// File: rtl/sg_mem_responder.sv
// Scatter/gather memory responder: word scratchpad, one-deep stage register and
// an in-order response FIFO. Define SG_ERR_CNT_EN to add a saturating error counter.
module sg_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SG_ERR_CNT_EN
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt,
`endif
  sg_mem_if.slave     bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]   mem_q [DEPTH];
  rsp_t          fifo_q [RSP_DEPTH];

  logic          s1_valid_q, s1_valid_d;
  rsp_t          s1_q, s1_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;

  logic [31:0]   off_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic          accept_s;
  logic          mem_wr_s;
  logic          push_s;
  logic          pop_s;
  rsp_t          head_s;

  // Address decode and accept qualification
  always_comb begin
    off_s    = bus.req_addr - BASE_ADDR;
    err_s    = (off_s[1:0] != 2'b00) || (off_s[31:2] >= 30'(DEPTH));
    idx_s    = off_s[AW+1:2];
    accept_s = bus.req_valid && req_ready_q;
    mem_wr_s = accept_s && bus.req_we && !err_s && !rst;
    push_s   = s1_valid_q;
    pop_s    = (cnt_q != {CW{1'b0}}) && bus.rsp_ready;
  end

  // Next-state for stage register, FIFO pointers/count and ready flag
  always_comb begin
    s1_valid_d = accept_s;
    s1_d       = '0;
    if (accept_s) begin
      s1_d.we  = bus.req_we;
      s1_d.err = err_s;
      if (bus.req_we || err_s) begin
        s1_d.data = 32'h0000_0000;
      end else begin
        s1_d.data = mem_q[idx_s];
      end
    end else begin
      s1_d = '0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // Registered ready: everything in flight must still fit in the FIFO
    req_ready_d = (int'(cnt_d) + int'(s1_valid_d)) < int'(RSP_DEPTH);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      req_ready_q <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Scratchpad write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_q[idx_s] <= bus.req_wdata;
    end
  end

  // Response FIFO storage; stale entries are masked by the count
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= s1_q;
    end
  end

  // Response channel shows the FIFO head, zeroed while empty
  always_comb begin
    head_s        = fifo_q[rd_ptr_q];
    bus.rsp_valid = (cnt_q != {CW{1'b0}});
    if (bus.rsp_valid) begin
      bus.rsp_data = head_s.data;
      bus.rsp_err  = head_s.err;
      bus.rsp_we   = head_s.we;
    end else begin
      bus.rsp_data = 32'h0000_0000;
      bus.rsp_err  = 1'b0;
      bus.rsp_we   = 1'b0;
    end
  end

  assign bus.req_ready = req_ready_q;

`ifdef SG_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; clear wins over increment
  always_comb begin
    if (err_cnt_clr) begin
      err_cnt_d = 16'h0000;
    end else if (accept_s && err_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'h0001;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sg_mem_responder.sv
// Self-checking bench for sg_mem_responder: directed table, hand sequences and
// randomized traffic checked against a queue/array reference model.
module tb_sg_mem_responder;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int unsigned RSP_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sg_mem_if bus ();

`ifdef SG_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
  logic [15:0] err_exp = 16'h0000;
`endif

  sg_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SG_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr),
    .err_cnt(err_cnt),
`endif
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic        stall_prev = 1'b0;
  logic [33:0] stall_val;
  logic [33:0] last_rsp;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: decode a request straight from the address rules
  function automatic exp_t model_req(logic we, logic [31:0] addr, logic [31:0] wd);
    exp_t        e;
    logic [31:0] off;
    off    = addr - BASE;
    e.we   = we;
    e.cyc  = cyc;
    e.data = 32'h0;
    e.err  = (addr % 4 != 0) || (off / 4 >= DEPTH);
    if (!e.err) begin
      if (we) mem_m[off / 4] = wd;
      else    e.data = mem_m[off / 4];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    logic exp_rv;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
`ifdef SG_ERR_CNT_EN
      err_exp = 16'h0000;
`endif
    end else begin
      exp_rv = 1'b0;
      if (exp_q.size() > 0) exp_rv = (exp_q[0].cyc + 2 <= cyc);
      check("req_ready", bus.req_ready, exp_q.size() < RSP_DEPTH);
      check("rsp_valid", bus.rsp_valid, exp_rv);
`ifdef SG_ERR_CNT_EN
      check("err_cnt", err_cnt, err_exp);
`endif
      if (stall_prev)
        check("rsp_hold", {bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_data}, {1'b1, stall_val});
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_rsp = {bus.rsp_we, bus.rsp_err, bus.rsp_data};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stale_rsp: got %0h expected no response", last_rsp);
        end else begin
          e = exp_q.pop_front();
          check("rsp", last_rsp, {e.we, e.err, e.data});
        end
      end
      stall_prev = bus.rsp_valid && !bus.rsp_ready;
      stall_val  = {bus.rsp_we, bus.rsp_err, bus.rsp_data};
      if (bus.req_valid && bus.req_ready) begin
        e = model_req(bus.req_we, bus.req_addr, bus.req_wdata);
        exp_q.push_back(e);
`ifdef SG_ERR_CNT_EN
        if (!err_cnt_clr && e.err && err_exp != 16'hFFFF) err_exp = err_exp + 16'h0001;
`endif
      end
`ifdef SG_ERR_CNT_EN
      if (err_cnt_clr) err_exp = 16'h0000;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int waited);
    logic a;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    waited = 0;
    a = 1'b0;
    while (!a && waited < 50) begin
      a = bus.req_ready;
      step();
      waited++;
    end
    if (!a) check("issue_accept", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      step();
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  vec_t vec[13];
  int   w;
  int   tot;
  int   n_acc;
  logic a;

  initial begin
    vec[0]  = '{1'b1, BASE + 32'h3FC, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vec[1]  = '{1'b0, BASE + 32'h3FC, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vec[2]  = '{1'b0, BASE + 32'h400, 32'h0,         1'b0, 1'b1, 32'h0};
    vec[3]  = '{1'b1, BASE + 32'h400, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
    vec[4]  = '{1'b0, BASE + 32'h002, 32'h0,         1'b0, 1'b1, 32'h0};
    vec[5]  = '{1'b0, BASE - 32'h004, 32'h0,         1'b0, 1'b1, 32'h0};
    vec[6]  = '{1'b1, BASE + 32'h005, 32'h1111_1111, 1'b1, 1'b1, 32'h0};
    vec[7]  = '{1'b0, BASE + 32'h000, 32'h0,         1'b0, 1'b0, 32'hC0DE_0000};
    vec[8]  = '{1'b0, BASE + 32'h004, 32'h0,         1'b0, 1'b0, 32'hC0DE_0001};
    vec[9]  = '{1'b0, BASE + 32'h008, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
    vec[10] = '{1'b1, BASE + 32'h010, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vec[11] = '{1'b0, BASE + 32'h010, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D};
    vec[12] = '{1'b0, BASE + 32'h3F8, 32'h0,         1'b0, 1'b0, 32'hC0DE_00FE};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_outputs", {bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_data}, 35'h0);
    check("rst_ready", bus.req_ready, 1'b1);

    // Preload every word with a known pattern, streamed back to back
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i), w);
    drain();

    // Write then read the same word on consecutive accepts; check latency
    issue(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, w);
    check("lat_write_plus1", bus.rsp_valid, 1'b0);
    issue(1'b0, BASE + 32'h8, 32'h0, w);
    check("lat_write_plus2", bus.rsp_valid, 1'b1);
    drain();
    check("raw_data", last_rsp, {1'b0, 1'b0, 32'hDEAD_BEEF});

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      issue(vec[i].we, vec[i].addr, vec[i].wdata, w);
      drain();
      check($sformatf("vec%0d", i), last_rsp, {vec[i].exp_we, vec[i].exp_err, vec[i].exp_data});
    end

`ifdef SG_ERR_CNT_EN
    check("err_cnt_table", err_cnt, 16'd5);
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    check("err_cnt_clr", err_cnt, 16'd0);
`endif

    // Backpressure: only RSP_DEPTH requests fit while the consumer stalls
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 8; t++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = BASE + 32'(4 * (40 + n_acc));
      a = bus.req_ready;
      step();
      if (a) n_acc++;
    end
    check("bp_accepted", n_acc, RSP_DEPTH);
    check("bp_ready_low", bus.req_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 40 && n_acc < 6; t++) begin
      bus.req_addr = BASE + 32'(4 * (40 + n_acc));
      a = bus.req_ready;
      step();
      if (a) n_acc++;
    end
    bus.req_valid = 1'b0;
    check("bp_total", n_acc, 6);
    drain();

    // Sustained stream of 16 reads: one accept per cycle
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, BASE + 32'(4 * (100 + i)), 32'h0, w);
      tot += w;
    end
    check("stream_cycles", tot, 16);
    drain();

    // Reset with responses queued: nothing stale may emerge, memory survives
    bus.rsp_ready = 1'b0;
    issue(1'b1, BASE + 32'h20, 32'h5A5A_0001, w);
    issue(1'b0, BASE + 32'h24, 32'h0, w);
    issue(1'b0, BASE + 32'h28, 32'h0, w);
    step();
    step();
    check("pre_rst_valid", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_valid", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) step();
    issue(1'b0, BASE + 32'h20, 32'h0, w);
    drain();
    check("post_rst_mem", last_rsp, {1'b0, 1'b0, 32'h5A5A_0001});

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_we    = $urandom_range(0, 1);
      bus.req_wdata = $urandom;
      bus.req_addr  = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if (sel == 0) bus.req_addr = bus.req_addr + 32'($urandom_range(1, 3));
      else if (sel == 1) bus.req_addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 63)));
      else if (sel == 2) bus.req_addr = BASE - 32'(4 * $urandom_range(1, 64));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
